// File: rtl/line_window_buffer.sv
// line_window_buffer
// Ring of NUM_BUF line buffers. Incoming pixels are packed with their H_TAPS-1
// left neighbours into one word per column. Reads return the V_TAPS oldest
// complete lines at one column as a V_TAPS x H_TAPS pixel window.
module line_window_buffer #(
  parameter int DATA_W    = 24,
  parameter int MAX_WIDTH = 1920,
  parameter int NUM_BUF   = 5,
  parameter int V_TAPS    = 4,
  parameter int H_TAPS    = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sof_i,
  input  logic [10:0]                        img_width,
  input  logic                               valid_i,
  input  logic [DATA_W-1:0]                  data_i,
  output logic                               wr_ready,
  output logic                               ovf,
  input  logic                               rd_en,
  input  logic [10:0]                        rd_addr,
  input  logic                               rd_finish,
  output logic                               rd_ready,
  output logic [$clog2(NUM_BUF+1)-1:0]       lines_avail,
  output logic                               valid_o,
  output logic [DATA_W*H_TAPS*V_TAPS-1:0]    win_o
);

  localparam int ROW_W  = DATA_W * H_TAPS;
  localparam int PTR_W  = $clog2(NUM_BUF);
  localparam int CNT_W  = $clog2(NUM_BUF + 1);
  localparam int ADDR_W = $clog2(MAX_WIDTH);
  localparam logic [PTR_W-1:0] LAST_BUF  = PTR_W'(NUM_BUF - 1);
  localparam logic [CNT_W-1:0] NUM_BUF_C = CNT_W'(NUM_BUF);

  // Buffer index k positions after p around the ring (k < NUM_BUF).
  function automatic logic [PTR_W-1:0] ring_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_BUF) s = s - NUM_BUF;
    return PTR_W'(s);
  endfunction

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [NUM_BUF-1:0] full;
  logic [CNT_W-1:0]   cnt;
  logic [10:0]        x;
  logic [ROW_W-1:0]   hist;

  // State as seen by this cycle's write/release, i.e. already cleared by sof_i.
  logic [PTR_W-1:0]   wr_ptr_e;
  logic [PTR_W-1:0]   rd_ptr_e;
  logic [NUM_BUF-1:0] full_e;
  logic [NUM_BUF-1:0] full_n;
  logic [CNT_W-1:0]   cnt_e;
  logic [CNT_W-1:0]   cnt_n;
  logic [10:0]        x_e;
  logic [ROW_W-1:0]   hist_e;
  logic [ROW_W-1:0]   wr_word;
  logic               accept;
  logic               eol;
  logic               fin;

  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr_c;
  logic [ROW_W-1:0]   rd_bus [NUM_BUF];
  logic               rd_en_d1;
  logic [PTR_W-1:0]   rd_ptr_d1;

  assign lines_avail = cnt;
  assign wr_ready    = (cnt < NUM_BUF_C);
  assign wr_addr     = x_e[ADDR_W-1:0];
  assign rd_addr_c   = (int'(rd_addr) < MAX_WIDTH) ? rd_addr[ADDR_W-1:0] : '0;

  // Window is readable only when the V_TAPS buffers from rd_ptr are all complete.
  always_comb begin
    rd_ready = 1'b1;
    for (int k = 0; k < V_TAPS; k++) begin
      rd_ready = rd_ready & full[ring_add(rd_ptr, k)];
    end
  end

  // Apply frame-start clearing, then decide accept/eol/release and next full/count.
  always_comb begin
    wr_ptr_e = wr_ptr;
    rd_ptr_e = rd_ptr;
    full_e   = full;
    cnt_e    = cnt;
    x_e      = x;
    hist_e   = hist;
    if (sof_i) begin
      wr_ptr_e = '0;
      rd_ptr_e = '0;
      full_e   = '0;
      cnt_e    = '0;
      x_e      = '0;
      hist_e   = '0;
    end
    accept  = valid_i && (cnt_e < NUM_BUF_C);
    eol     = accept && (x_e == (img_width - 11'd1));
    fin     = rd_finish && rd_ready && !sof_i;
    wr_word = (hist_e << DATA_W) | ROW_W'(data_i);
    full_n  = full_e;
    if (eol) full_n[wr_ptr_e] = 1'b1;
    if (fin) full_n[rd_ptr_e] = 1'b0;
    cnt_n = cnt_e;
    if (eol && !fin) cnt_n = cnt_e + CNT_W'(1);
    if (fin && !eol) cnt_n = cnt_e - CNT_W'(1);
  end

  // Write-side and ring bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= '0;
      cnt    <= '0;
      x      <= '0;
      hist   <= '0;
      ovf    <= 1'b0;
    end else begin
      full <= full_n;
      cnt  <= cnt_n;
      if (accept) begin
        x    <= eol ? 11'd0 : (x_e + 11'd1);
        hist <= eol ? '0 : wr_word;
      end else begin
        x    <= x_e;
        hist <= hist_e;
      end
      if (eol) wr_ptr <= (wr_ptr_e == LAST_BUF) ? '0 : (wr_ptr_e + PTR_W'(1));
      else     wr_ptr <= wr_ptr_e;
      if (fin) rd_ptr <= (rd_ptr_e == LAST_BUF) ? '0 : (rd_ptr_e + PTR_W'(1));
      else     rd_ptr <= rd_ptr_e;
      ovf <= sof_i ? 1'b0 : (ovf | (valid_i && !accept));
    end
  end

  // One simple dual-port RAM per line buffer; every buffer is read on rd_en.
  for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
    logic [ROW_W-1:0] mem [MAX_WIDTH];
    logic [ROW_W-1:0] rd_q;

    // Registered read and write of this buffer's line storage.
    always_ff @(posedge clk) begin
      if (accept && !reset && (wr_ptr_e == PTR_W'(b))) mem[wr_addr] <= wr_word;
      if (rd_en) rd_q <= mem[rd_addr_c];
    end

    assign rd_bus[b] = rd_q;
  end

  // Output register: reorder RAM words so the oldest line lands in row 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_d1  <= 1'b0;
      rd_ptr_d1 <= '0;
      valid_o   <= 1'b0;
      win_o     <= '0;
    end else begin
      rd_en_d1 <= rd_en;
      if (rd_en) rd_ptr_d1 <= rd_ptr;
      valid_o  <= rd_en_d1;
      if (rd_en_d1) begin
        for (int k = 0; k < V_TAPS; k++) begin
          win_o[k*ROW_W +: ROW_W] <= rd_bus[ring_add(rd_ptr_d1, k)];
        end
      end
    end
  end

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel width in bits.
REQ-002 SHALL have parameter MAX_WIDTH, default 1920, maximum pixels per line and RAM depth per buffer.
REQ-003 SHALL have parameter NUM_BUF, default 5, ring line-buffer count, legal range V_TAPS+1..8.
REQ-004 SHALL have parameter V_TAPS, default 4, rows presented per read, legal range 2..7.
REQ-005 SHALL have parameter H_TAPS, default 4, horizontal pixels per stored word, legal range 1..8.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port sof_i  input  1  frame start; synchronous clear of the ring.
REQ-009 SHALL have port img_width  input  11  active pixels per line, 1..MAX_WIDTH, stable within a frame.
REQ-010 SHALL have ports valid_i input 1 and data_i input DATA_W, the pixel stream, one pixel per valid cycle.
REQ-011 SHALL have port wr_ready  output  1  high while at least one buffer is not full.
REQ-012 SHALL have port ovf  output  1  sticky; pixel dropped due to no free buffer.
REQ-013 SHALL have ports rd_en input 1, rd_addr input 11, rd_finish input 1: read strobe, column address, release of oldest line.
REQ-014 SHALL have port rd_ready  output  1  the V_TAPS lines starting at the read pointer are full.
REQ-015 SHALL have port lines_avail  output  clog2(NUM_BUF+1)  count of full buffers.
REQ-016 SHALL have ports valid_o output 1 and win_o output DATA_W*H_TAPS*V_TAPS: the read window.

Function
REQ-017 SHALL accept a pixel when valid_i && wr_ready; pixel dropped and ovf set when valid_i && !wr_ready.
REQ-018 SHALL keep a column counter x (0..img_width-1); an accepted pixel at x == img_width-1 is end-of-line (eol), and x returns to 0.
REQ-019 SHALL write, in the accept cycle, word {p[x-H_TAPS+1],...,p[x-1],p[x]} (p[x] in LSBs) to address x of buffer wr_ptr; p[n<0] SHALL be zero, so the horizontal shift register clears on eol.
REQ-020 SHALL, on eol, set full[wr_ptr] and advance wr_ptr modulo NUM_BUF (NUM_BUF-1 wraps to 0).
REQ-021 SHALL, on rd_finish && rd_ready, clear full[rd_ptr] and advance rd_ptr modulo NUM_BUF; rd_finish while !rd_ready SHALL be ignored.
REQ-022 SHALL apply eol set and rd_finish clear in the same cycle independently; lines_avail SHALL change by net (+1,-1,0).
REQ-023 SHALL drive wr_ready = (lines_avail < NUM_BUF) combinationally from registered state.
REQ-024 SHALL drive rd_ready = full[rd_ptr+k mod NUM_BUF] for all k in 0..V_TAPS-1.
REQ-025 SHALL read all buffers at rd_addr when rd_en; valid_o SHALL go high exactly 2 cycles after rd_en (RAM stage plus output register), one pulse per rd_en.
REQ-026 SHALL place row k (buffer rd_ptr+k mod NUM_BUF, k=0 oldest) at win_o bits [(k+1)*DATA_W*H_TAPS-1 : k*DATA_W*H_TAPS], using rd_ptr sampled with rd_en.
REQ-027 SHALL leave win_o content unspecified when rd_en occurs with !rd_ready or rd_addr >= img_width; valid_o still pulses.
REQ-028 SHALL, on sof_i, clear wr_ptr, rd_ptr, full[], x, shift register and ovf; valid_i in the same cycle SHALL be accepted as x=0 of the new frame; reads in flight complete with unspecified data.
REQ-029 SHALL support simultaneous write and read of the same address in different buffers at full rate with no stall.

Reset
REQ-030 SHALL, while reset high, hold wr_ptr=0, rd_ptr=0, full[]=0, x=0, ovf=0, valid_o=0, win_o=0, lines_avail=0; wr_ready=1, rd_ready=0; reset SHALL override sof_i and all strobes.
REQ-031 SHALL not require RAM contents to be cleared by reset.

Verification
REQ-032 Defaults, img_width=8, write 4 lines p=line*16+x -> lines_avail=4, rd_ready=1 on the cycle after 32nd pixel; rd_en addr 5 -> valid_o 2 cycles later, row0 LSB pixel=0x05, row3 LSB=0x35, row0 MSB pixel=0x02.
REQ-033 img_width=8, rd_addr=1 on line 0 -> row0 = {0,0,p0,p1}, left-edge zero fill.
REQ-034 Fill 5 lines, no rd_finish -> wr_ready=0; 6th-line pixel dropped, ovf=1; rd_finish -> wr_ready=1, lines_avail=4.
REQ-035 rd_finish same cycle as eol with lines_avail=4 -> lines_avail stays 4, wr_ptr and rd_ptr both advance; run 12 lines to exercise wrap 4->0.
REQ-036 sof_i mid-line (x=3, lines_avail=2) with valid_i -> lines_avail=0, ovf=0, that pixel stored at address 0 of buffer 0.
REQ-037 reset asserted during rd_en pipeline -> valid_o=0 next cycle, all outputs at reset values.
